// File: rtl/decoder_pipe.sv
// Registered binary-to-one-hot decoder with a single-entry valid/ready output stage.
// Define DECODER_PIPE_ERR_CNT_EN to add a saturating 8-bit out-of-range counter (err_cnt).
module decoder_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_N = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [OUT_N-1:0] q,
    output logic             q_err,
    output logic             q_valid,
`ifdef DECODER_PIPE_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    input  logic             q_ready
);

    logic [OUT_N-1:0] q_vec_q, q_vec_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [OUT_N-1:0] onehot;
    logic             in_range;
    logic             accept;

    // Comparisons use 9 bits so OUT_N = 256 with IN_W = 8 still fits.
    assign in_range = ({{(9-IN_W){1'b0}}, i} < 9'(OUT_N));

    for (genvar gi = 0; gi < OUT_N; gi++) begin : g_onehot
        assign onehot[gi] = (i == IN_W'(gi));
    end

    // Reset gates ready combinationally so nothing is accepted while rst is low.
    assign i_ready = rst & (~valid_q | q_ready);
    assign accept  = i_valid & i_ready;

    always_comb begin
        q_vec_d = q_vec_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
            err_d   = ~in_range;
            q_vec_d = in_range ? onehot : '0;
        end else if (q_ready) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            q_vec_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_vec_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            q_vec_q <= q_vec_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign q       = q_vec_q;
    assign q_err   = err_q;
    assign q_valid = valid_q;

`ifdef DECODER_PIPE_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !in_range && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: full-range instance (OUT_N=8) and a
// truncated instance (OUT_N=6) for out-of-range handling.
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] i = '0;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic [7:0] q;
    logic       q_err;
    logic       q_valid;
    logic       q_ready = 1'b0;

    logic [2:0] e_i = '0;
    logic       e_valid = 1'b0;
    logic       e_iready;
    logic [5:0] e_q;
    logic       e_qerr;
    logic       e_qvalid;
    logic       e_qready = 1'b1;
`ifdef DECODER_PIPE_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic [7:0] e_errcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_pipe #(.IN_W(3), .OUT_N(8)) u_dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
        .q(q), .q_err(q_err), .q_valid(q_valid),
`ifdef DECODER_PIPE_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .q_ready(q_ready)
    );

    decoder_pipe #(.IN_W(3), .OUT_N(6)) u_err (
        .clk(clk), .rst(rst), .i(e_i), .i_valid(e_valid), .i_ready(e_iready),
        .q(e_q), .q_err(e_qerr), .q_valid(e_qvalid),
`ifdef DECODER_PIPE_ERR_CNT_EN
        .err_cnt(e_errcnt),
`endif
        .q_ready(e_qready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic       m_valid;
        logic       m_ready;
        int         sent;
        int         got;
        int         budget;

        // Reset state
        #2;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qvalid", 32'(q_valid), 32'h0);
        chk("rst_qerr", 32'(q_err), 32'h0);
        chk("rst_iready", 32'(i_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_iready", 32'(i_ready), 32'h1);
        $display("reset released at %0t", $time);

        // Streaming 0..7 with q_ready held high
        q_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i = 3'(k);
            i_valid = 1'b1;
            step();
            chk("stream_q", 32'(q), 32'(8'h1 << k));
            chk("stream_qvalid", 32'(q_valid), 32'h1);
            chk("stream_qerr", 32'(q_err), 32'h0);
            $display("stream code=%0d q=%02h valid=%0b", k, q, q_valid);
        end
        i_valid = 1'b0;
        step();
        chk("drain_qvalid", 32'(q_valid), 32'h0);
        chk("drain_q", 32'(q), 32'h0);

        // Backpressure: hold 5 for four cycles while i changes
        i = 3'd5;
        i_valid = 1'b1;
        step();
        chk("bp_load", 32'(q), 32'h20);
        q_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i = 3'(k);
            #1;
            chk("bp_iready", 32'(i_ready), 32'h0);
            step();
            chk("bp_hold_q", 32'(q), 32'h20);
            chk("bp_hold_valid", 32'(q_valid), 32'h1);
            $display("backpressure cycle=%0d q=%02h i_ready=%0b", k, q, i_ready);
        end
        i_valid = 1'b0;
        q_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(q_valid), 32'h0);
        chk("bp_release_q", 32'(q), 32'h0);

        // Asynchronous reset while a result is held
        i = 3'd3;
        i_valid = 1'b1;
        step();
        chk("ar_load", 32'(q), 32'h08);
        i_valid = 1'b0;
        q_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("ar_q", 32'(q), 32'h0);
        chk("ar_valid", 32'(q_valid), 32'h0);
        chk("ar_iready", 32'(i_ready), 32'h0);
        i = 3'd4;
        i_valid = 1'b1;
        q_ready = 1'b1;
        step();
        chk("ar_noaccept", 32'(q_valid), 32'h0);
        rst = 1'b1;
        i = 3'd1;
        step();
        chk("ar_after_q", 32'(q), 32'h02);
        chk("ar_after_valid", 32'(q_valid), 32'h1);
        $display("async reset recovery q=%02h", q);
        i_valid = 1'b0;
        step();

        // Out-of-range codes on the OUT_N=6 instance
        e_i = 3'd6;
        e_valid = 1'b1;
        step();
        chk("oor6_q", 32'(e_q), 32'h0);
        chk("oor6_err", 32'(e_qerr), 32'h1);
        chk("oor6_valid", 32'(e_qvalid), 32'h1);
        e_i = 3'd7;
        step();
        chk("oor7_q", 32'(e_q), 32'h0);
        chk("oor7_err", 32'(e_qerr), 32'h1);
        e_i = 3'd5;
        step();
        chk("inr5_q", 32'(e_q), 32'h20);
        chk("inr5_err", 32'(e_qerr), 32'h0);
        e_valid = 1'b0;
        step();
        chk("oor_clear_err", 32'(e_qerr), 32'h0);
        $display("out-of-range instance done");
`ifdef DECODER_PIPE_ERR_CNT_EN
        chk("errcnt_2", 32'(e_errcnt), 32'd2);
        e_i = 3'd7;
        e_valid = 1'b1;
        for (int k = 0; k < 300; k++) step();
        e_valid = 1'b0;
        step();
        chk("errcnt_sat", 32'(e_errcnt), 32'd255);
        chk("errcnt_main", 32'(err_cnt), 32'd0);
        $display("err_cnt saturated at %0d", e_errcnt);
`endif

        // Random valid/ready toggling against a queue scoreboard
        m_valid = 1'b0;
        sent = 0;
        got = 0;
        budget = 0;
        while ((sent < 1000 || m_valid) && budget < 20000) begin
            budget++;
            i_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            q_ready = 1'($urandom_range(0, 3) != 0);
            i = 3'($urandom_range(0, 7));
            #1;
            m_ready = !m_valid || q_ready;
            if (i_ready !== m_ready) chk("rnd_iready", 32'(i_ready), 32'(m_ready));
            if (q_valid && q_ready) begin
                chk("rnd_q", 32'(q), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
            end
            if (i_valid && m_ready) begin
                exp_q.push_back(8'h1 << i);
                sent++;
                m_valid = 1'b1;
            end else if (q_ready) begin
                m_valid = 1'b0;
            end
            step();
        end
        chk("rnd_budget", 32'(budget < 20000), 32'h1);
        chk("rnd_count", 32'(got), 32'(sent));
        chk("rnd_empty", 32'(exp_q.size()), 32'h0);
        $display("random test sent=%0d received=%0d", sent, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
